// File: rtl/load_ext_pipe_if.sv
// Handshake bundle for the load-extension pipe: upstream entry channel
// (raw word, offset, size, signedness) and downstream result channel.
interface load_ext_pipe_if #(
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic [1:0]        in_size;
  logic              in_signed;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  // Environment side: produces entries, consumes results.
  modport master (
    output in_valid, in_data, in_off, in_size, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  // Pipe side: consumes entries, produces results.
  modport slave (
    input  in_valid, in_data, in_off, in_size, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/load_ext_pipe.sv
// Load-data alignment and extension stage. Each entry selects a byte, half,
// word or dword lane from the raw read word, shifts it to bit 0 and sign- or
// zero-extends it. The result is registered into an output register backed
// by a one-entry skid register, so in_ready can come straight from a flop.
module load_ext_pipe #(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input logic           clk,
  input logic           resetn,
  input logic           flush,
  load_ext_pipe_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Align and extend one access; misaligned or oversize accesses yield err=1
  // with zero data.
  function automatic entry_t extend(
    input logic [DATA_W-1:0] data,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              sgn
  );
    entry_t            e;
    int                bytes;
    int                bits;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic [IDX_W-1:0]  sign_idx;
    logic              msb;
    bytes    = 1 << size;
    bits     = bytes * 8;
    shifted  = data >> {off, 3'b000};
    // Shifting the all-ones mask by DATA_W leaves keep all-ones, so a
    // full-width access passes through with no fill.
    keep     = ~({DATA_W{1'b1}} << bits);
    sign_idx = IDX_W'(bits - 1);
    msb      = shifted[sign_idx];
    e.err    = (bits > DATA_W) || ((32'(off) & (bytes - 1)) != 0);
    if (e.err) begin
      e.data = '0;
    end else begin
      e.data = (shifted & keep) | ((sgn && msb) ? ~keep : '0);
    end
    return e;
  endfunction

  state_e state_q;
  state_e state_d;
  logic   in_ready_q;
  entry_t out_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;
  logic   load_out;
  logic   load_skid;
  logic   move_skid;

  // Extension happens on the incoming entry, before it is registered.
  assign in_entry = extend(bus.in_data, bus.in_off, bus.in_size, bus.in_signed);

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = (state_q != EMPTY) & bus.out_ready;

  // State register; in_ready is registered from the next state so it never
  // sees out_ready combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Next-state logic; flush overrides every transfer.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) state_d = ONE;
        ONE: begin
          if (in_xfer && !out_xfer)      state_d = TWO;
          else if (!in_xfer && out_xfer) state_d = EMPTY;
        end
        TWO:     if (out_xfer) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath load enables decoded from state and the two handshakes.
  always_comb begin
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: load_out = in_xfer;
        ONE: begin
          load_out  = in_xfer && out_xfer;
          load_skid = in_xfer && !out_xfer;
        end
        TWO:     move_skid = out_xfer;
        default: ;
      endcase
    end
  end

  // Output and skid registers; the output register only changes on a load,
  // so a stalled result holds stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: datapath registers are reset here because the result must read
      // zero while reset is held, not just be marked invalid.
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out) begin
        out_q <= in_entry;
      end else if (move_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = out_q.data;
  assign bus.out_err   = out_q.err;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Self-checking bench for load_ext_pipe: directed vectors, a stall/flush
// sequence and a long randomized run on a 32-bit instance against a queue
// scoreboard, plus a 64-bit instance streamed against the same model.
module tb_load_ext_pipe;

  logic clk = 1'b0;
  logic resetn;
  logic flush32;
  logic flush64;

  always #5 clk = ~clk;

  load_ext_pipe_if #(.DATA_W(32)) bus32 ();
  load_ext_pipe_if #(.DATA_W(64)) bus64 ();

  load_ext_pipe #(.DATA_W(32)) dut32 (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush32),
    .bus    (bus32.slave)
  );

  load_ext_pipe #(.DATA_W(64)) dut64 (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush64),
    .bus    (bus64.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pick the field arithmetically, then wrap negative values
  // into the result width. Returns {err, data}.
  function automatic logic [64:0] ref_ext(input int w, input logic [63:0] data,
                                          input int off, input int size, input bit sgn);
    logic [127:0] field;
    logic [127:0] span;
    logic [127:0] modw;
    int bytes = 1 << size;
    int bits  = 8 * bytes;
    if (bits > w || (off % bytes) != 0) return {1'b1, 64'd0};
    span  = 128'd1 << bits;
    modw  = 128'd1 << w;
    field = ({64'd0, data} >> (8 * off)) % span;
    if (sgn && field >= (span >> 1)) field = field + modw - span;
    field = field % modw;
    return {1'b0, field[63:0]};
  endfunction

  // Stimulus for the 32-bit instance, applied by step().
  bit          d_valid;
  logic [31:0] d_data;
  int          d_off;
  int          d_size;
  bit          d_sgn;
  bit          d_ordy;
  bit          d_flush;

  logic [64:0] q32[$];
  bit          prev_stall;
  logic [32:0] prev_out;
  int          accepted;

  task automatic set_in(input bit v, input logic [31:0] d, input int off,
                        input int size, input bit sgn);
    d_valid = v; d_data = d; d_off = off; d_size = size; d_sgn = sgn;
  endtask

  // One cycle: drive at negedge, check and score just after, before the edge.
  task automatic step(input bit probe = 1'b0);
    logic [64:0] exp;
    @(negedge clk);
    bus32.in_valid  = d_valid;
    bus32.in_data   = d_data;
    bus32.in_off    = 2'(d_off);
    bus32.in_size   = 2'(d_size);
    bus32.in_signed = d_sgn;
    bus32.out_ready = d_ordy;
    flush32         = d_flush;
    #1;
    check("in_ready", bus32.in_ready, q32.size() < 2);
    check("out_valid", bus32.out_valid, q32.size() > 0);
    if (probe) begin
      bus32.out_ready = ~d_ordy;
      #1;
      check("in_ready_vs_out_ready", bus32.in_ready, q32.size() < 2);
      bus32.out_ready = d_ordy;
      #1;
    end
    if (prev_stall) begin
      check("hold_data", bus32.out_data, prev_out[31:0]);
      check("hold_err", bus32.out_err, prev_out[32]);
    end
    prev_stall = bus32.out_valid && !bus32.out_ready && !d_flush;
    prev_out   = {bus32.out_err, bus32.out_data};
    if (d_flush) begin
      q32.delete();
    end else begin
      if (bus32.out_valid && bus32.out_ready) begin
        if (q32.size() == 0) begin
          check("out_when_empty", bus32.out_valid, 1'b0);
        end else begin
          exp = q32.pop_front();
          check("out_data", bus32.out_data, exp[31:0]);
          check("out_err", bus32.out_err, exp[64]);
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back(ref_ext(32, {32'd0, d_data}, d_off, d_size, d_sgn));
        accepted++;
      end
    end
  endtask

  initial begin
    logic [64:0] exp64_prev;
    logic [64:0] exp64_cur;
    logic [63:0] r64;
    int          off64;
    int          size64;
    bit          sgn64;
    int          cyc;

    resetn = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_off = '0;
    bus32.in_size = '0; bus32.in_signed = 1'b0; bus32.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_off = '0;
    bus64.in_size = '0; bus64.in_signed = 1'b0; bus64.out_ready = 1'b1;
    set_in(0, '0, 0, 0, 0); d_ordy = 1'b1; d_flush = 1'b0;
    prev_stall = 1'b0; prev_out = '0; accepted = 0;

    // Reset state before any clock edge.
    #2;
    check("rst_out_valid", bus32.out_valid, 1'b0);
    check("rst_in_ready", bus32.in_ready, 1'b0);
    check("rst_out_data", bus32.out_data, 32'd0);
    check("rst_out_err", bus32.out_err, 1'b0);

    // First edge after release only raises in_ready; the offered entry is ignored.
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus32.in_valid = 1'b1; bus32.in_data = 32'hDEAD_BEEF;
    #1;
    check("rel_in_ready_low", bus32.in_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_in_ready_high", bus32.in_ready, 1'b1);
    check("rel_no_accept", bus32.out_valid, 1'b0);

    // Byte lanes, signed.
    set_in(1, 32'h80F0_7F01, 1, 0, 1); step();
    set_in(1, 32'h80F0_7F01, 3, 0, 1); step();
    check("byte_off1_signed", bus32.out_data, 32'h0000_007F);
    check("byte_off1_err", bus32.out_err, 1'b0);
    // Half lanes: signed, unsigned, misaligned.
    set_in(1, 32'h1234_8765, 0, 1, 1); step();
    check("byte_off3_signed", bus32.out_data, 32'hFFFF_FF80);
    set_in(1, 32'h1234_8765, 0, 1, 0); step();
    check("half_signed", bus32.out_data, 32'hFFFF_8765);
    set_in(1, 32'h1234_8765, 1, 1, 1); step();
    check("half_unsigned", bus32.out_data, 32'h0000_8765);
    set_in(1, 32'h1234_8765, 0, 3, 0); step();
    check("half_misaligned_err", bus32.out_err, 1'b1);
    check("half_misaligned_data", bus32.out_data, 32'd0);
    set_in(0, '0, 0, 0, 0); step();
    check("dword_on_32_err", bus32.out_err, 1'b1);
    step();

    // Back-to-back A, B, C with the consumer stalled.
    d_ordy = 1'b0;
    set_in(1, 32'h1111_1111, 0, 2, 0); step();
    set_in(1, 32'h2222_2222, 0, 2, 0); step();
    set_in(1, 32'h3333_3333, 0, 2, 0); step();
    check("stall_holds_a", bus32.out_data, 32'h1111_1111);
    check("stall_full", bus32.in_ready, 1'b0);
    step(); step();
    check("stall_still_a", bus32.out_data, 32'h1111_1111);
    d_ordy = 1'b1; step();
    step();
    check("drain_b", bus32.out_data, 32'h2222_2222);
    set_in(0, '0, 0, 0, 0); step();
    check("drain_c", bus32.out_data, 32'h3333_3333);
    step();

    // Fill both entries, then flush with a simultaneous input.
    d_ordy = 1'b0;
    set_in(1, 32'hAAAA_0001, 0, 2, 0); step();
    set_in(1, 32'hAAAA_0002, 0, 2, 0); step();
    set_in(1, 32'hAAAA_0003, 0, 2, 0); d_flush = 1'b1; step();
    d_flush = 1'b0; set_in(0, '0, 0, 0, 0); step();
    check("flush_out_valid", bus32.out_valid, 1'b0);
    check("flush_in_ready", bus32.in_ready, 1'b1);
    d_ordy = 1'b1; step(); step();

    // Randomized handshakes against the scoreboard.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      d_valid = ($urandom_range(0, 9) < 7);
      d_data  = $urandom();
      d_size  = $urandom_range(0, 3);
      d_off   = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) d_off = d_off & ~((1 << d_size) - 1);
      d_sgn   = $urandom_range(0, 1);
      d_ordy  = ($urandom_range(0, 9) < 7);
      d_flush = ($urandom_range(0, 499) == 0);
      step((cyc % 16) == 0);
      cyc++;
    end
    check("rand_entries_reached", accepted >= 10000, 1'b1);
    set_in(0, '0, 0, 0, 0); d_ordy = 1'b1; d_flush = 1'b0;
    repeat (4) step();

    // 64-bit instance: continuous stream with the consumer always ready.
    exp64_prev = {1'b0, 64'hFFFF_FFFF_FEDC_BA98};
    @(negedge clk);
    bus64.in_valid = 1'b1; bus64.in_data = 64'hFEDC_BA98_7654_3210;
    bus64.in_off = 3'd4; bus64.in_size = 2'd2; bus64.in_signed = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r64    = {$urandom(), $urandom()};
      size64 = $urandom_range(0, 3);
      off64  = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off64 = off64 & ~((1 << size64) - 1);
      sgn64  = $urandom_range(0, 1);
      exp64_cur = ref_ext(64, r64, off64, size64, sgn64);
      @(negedge clk);
      bus64.in_data = r64; bus64.in_off = 3'(off64);
      bus64.in_size = 2'(size64); bus64.in_signed = sgn64;
      #1;
      check(i == 0 ? "w64_word_off4_signed" : "w64_data", bus64.out_data, exp64_prev[63:0]);
      check("w64_err", bus64.out_err, exp64_prev[64]);
      check("w64_out_valid", bus64.out_valid, 1'b1);
      check("w64_in_ready", bus64.in_ready, 1'b1);
      exp64_prev = exp64_cur;
    end

    // Asynchronous reset mid-burst.
    #1;
    resetn = 1'b0;
    #1;
    check("arst_out_valid64", bus64.out_valid, 1'b0);
    check("arst_out_data64", bus64.out_data, 64'd0);
    check("arst_in_ready64", bus64.in_ready, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    bus64.in_valid = 1'b0;
    @(posedge clk); #1;
    check("arst_rel_in_ready64", bus64.in_ready, 1'b1);
    check("arst_discard64", bus64.out_valid, 1'b0);
    @(posedge clk); #1;
    check("arst_still_empty64", bus64.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
